// File: rtl/mod4051_chunk_accumulator.sv
// Serial modular accumulator: sums one W-bit residue per cycle modulo MODULUS
// and presents the reduced residue of each operand on a valid/ready output.
module mod4051_chunk_accumulator #(
  parameter int MODULUS = 4051,
  parameter int W       = 12,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  localparam logic [W:0] MOD_X = (W+1)'(MODULUS);

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic             err;

  logic             accept;
  logic             over;
  logic [W-1:0]     d;
  logic [W-1:0]     acc_nxt;

  // One conditional subtract is enough for any value below 2*MODULUS.
  function automatic logic [W-1:0] mod_reduce(input logic [W:0] s);
    logic [W:0] t;
    t = (s >= MOD_X) ? (s - MOD_X) : s;
    return t[W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : (c + CNT_W'(1));
  endfunction

  assign over    = ({1'b0, in_data} >= MOD_X);
  assign d       = mod_reduce({1'b0, in_data});
  assign acc_nxt = mod_reduce({1'b0, acc} + {1'b0, d});
  assign accept  = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      acc <= acc_nxt;
      cnt <= sat_inc(cnt);
      err <= err | over;
      if (in_last) begin
        out_data  <= acc_nxt;
        out_count <= sat_inc(cnt);
        out_err   <= err | over;
      end
    end else if (state == DONE && out_ready) begin
      // Running state is cleared on handshake; the result registers hold.
      acc <= '0;
      cnt <= '0;
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod4051_chunk_accumulator.sv
// Self-checking bench: directed cases plus random operands checked against a
// sum-then-modulo reference model.
module tb_mod4051_chunk_accumulator;

  localparam int M = 4051;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic [7:0]  out_count;
  logic        out_err;

  int total = 0;
  int bad   = 0;
  int terms[$];

  always #5 clk = ~clk;

  mod4051_chunk_accumulator #(.MODULUS(4051), .W(12), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_err(out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the queued terms back to back, then holds out_ready low for
  // 'hold' cycles before completing the result handshake.
  task automatic run_operand(input string tag, input int hold);
    int sum;
    int n;
    logic e;
    sum = 0;
    e = 1'b0;
    n = terms.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ".in_ready"}, 32'(in_ready), 1);
      check({tag, ".no_out_valid"}, 32'(out_valid), 0);
      in_valid = 1'b1;
      in_data  = 12'(terms[i]);
      in_last  = (i == n - 1);
      sum += terms[i];
      if (terms[i] >= M) e = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      check({tag, ".out_valid"}, 32'(out_valid), 1);
      check({tag, ".out_data"}, 32'(out_data), 32'(sum % M));
      check({tag, ".out_count"}, 32'(out_count), 32'((n > 255) ? 255 : n));
      check({tag, ".out_err"}, 32'(out_err), 32'(e));
      check({tag, ".in_ready_done"}, 32'(in_ready), 0);
      if (h == hold) out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check({tag, ".after_hs_valid"}, 32'(out_valid), 0);
    check({tag, ".after_hs_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      check("rst.in_ready", 32'(in_ready), 1);
      check("rst.out_valid", 32'(out_valid), 0);
      check("rst.out_data", 32'(out_data), 0);
      check("rst.out_count", 32'(out_count), 0);
      check("rst.out_err", 32'(out_err), 0);
      tick();
    end

    terms = '{4050, 1};        run_operand("wrap", 0);
    terms = '{2000, 2000, 100}; run_operand("multi", 1);
    terms = '{4095};           run_operand("nonnorm", 0);
    check("nonnorm.lit_data", 32'(out_data), 44);
    terms = '{5};              run_operand("after_err", 0);

    // Backpressure with a competing term presented while DONE
    terms = '{7, 9};
    in_valid = 1'b1; in_data = 12'd7; in_last = 1'b0; tick();
    in_data = 12'd9; in_last = 1'b1; tick();
    in_data = 12'd1000;
    for (int c = 0; c < 5; c++) begin
      check("bp.out_valid", 32'(out_valid), 1);
      check("bp.out_data", 32'(out_data), 16);
      check("bp.out_count", 32'(out_count), 2);
      check("bp.in_ready", 32'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; tick();
    out_ready = 1'b0;
    check("bp.released", 32'(out_valid), 0);
    terms = '{1000};           run_operand("bp_next", 0);

    // Asynchronous reset in the middle of an operand
    in_valid = 1'b1; in_last = 1'b0;
    in_data = 12'd3000; tick();
    in_data = 12'd3000; tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst.out_valid", 32'(out_valid), 0);
    check("midrst.out_data", 32'(out_data), 0);
    check("midrst.in_ready", 32'(in_ready), 1);
    #1 rst = 1'b0;
    tick();
    terms = '{10};             run_operand("midrst", 0);

    // Reset while a result is pending
    terms = '{123, 456};
    in_valid = 1'b1; in_data = 12'd123; in_last = 1'b0; tick();
    in_data = 12'd456; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("donerst.pre_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("donerst.out_valid", 32'(out_valid), 0);
    check("donerst.out_count", 32'(out_count), 0);
    #1 rst = 1'b0;
    tick();

    // Saturating term count
    terms = {};
    for (int i = 0; i < 300; i++) terms.push_back(1);
    run_operand("sat", 0);

    // Random operands, including non-normalised values
    for (int k = 0; k < 40; k++) begin
      int n;
      n = $urandom_range(1, 8);
      terms = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) terms.push_back($urandom_range(4051, 4095));
        else terms.push_back($urandom_range(0, 4095));
      end
      run_operand("rand", $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod4051_chunk_accumulator.md
# mod4051_chunk_accumulator

Serial modular accumulator directly downstream of the mod-4051 chunk LUT stage. Each cycle it accepts one 12-bit residue contribution from a chunk LUT and adds it into a running sum modulo 4051. When the last chunk of an operand is accepted, it presents the fully reduced residue of the whole operand on a valid/ready output. It converts the parallel LUT bank outputs into a single residue per operand.

## Interface
- MODULUS, 4051, modulus; must satisfy 2^(W-1) < MODULUS < 2^W.
- W, 12, residue width in bits.
- CNT_W, 8, width of the term counter.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block can accept a term this cycle.
- in_data  input  W  residue contribution; nominally < MODULUS.
- in_last  input  1  marks the final term of the operand.
- out_valid  output  1  out_data/out_count/out_err are valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  W  final residue, always < MODULUS.
- out_count  output  CNT_W  number of terms accepted for this operand, saturating.
- out_err  output  1  at least one in_data ≥ MODULUS was seen in this operand.

## Operation
- FSM states:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Input accept: occurs when in_valid & in_ready.
- Input normalisation: d = in_data ≥ MODULUS ? in_data − MODULUS : in_data.
  - A single subtract suffices because 2^W − 1 < 2·MODULUS.
  - The err flag is set sticky for the current operand whenever in_data ≥ MODULUS.
- Accumulate: s = acc + d, computed W+1 bits wide; acc_next = s ≥ MODULUS ? s − MODULUS : s.
  - Invariant: acc < MODULUS at all times.
- Count: cnt increments per accepted term and saturates at 2^CNT_W − 1; no wrap.
- On accept with in_last=1:
  - Registered result ← acc_next, out_count ← cnt+1 (saturated), out_err ← err | (in_data ≥ MODULUS).
  - Then go to DONE.
- DONE with out_ready=1: go to ACCUM with acc, cnt and err cleared to 0.
- DONE with out_ready=0: out_data, out_count and out_err are held stable.
- in_valid in DONE: ignored; in_ready=0, so no accept.
- Empty operand (first term carries in_last): legal. Result is d, count is 1.
- Reset at any time, including mid-operand or with out_valid high:
  - Partial sum discarded, state=ACCUM.
  - acc=0, cnt=0, err=0.
  - out_valid=0, out_data=0, out_count=0, out_err=0, in_ready=1 on the first edge after deassert.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_count=0, out_err=0.
- Throughput: one term per cycle in ACCUM; no bubbles within an operand.
- Latency: the last term accepted at edge N gives out_valid=1 with the final result after edge N (visible in cycle N+1).
- Result handshake: completes at the first edge where out_valid & out_ready. The next cycle is ACCUM with in_ready=1.
  - Minimum gap between operands is one cycle (the DONE cycle).
- in_ready is a pure function of state: no combinational path from out_ready or in_valid.
- out_* are driven directly from registers.
- Critical path: a W-bit compare/subtract, then a (W+1)-bit add, then a compare/subtract. Single cycle; no pipelining.

## Test plan
- Reset with no input: all outputs at their reset values for 10 cycles, in_ready=1.
- Wrap to zero: terms 4050, then 1 (last) → out_data=0, out_count=2, out_err=0, out_valid one cycle after the last accept.
- Multi-term wrap: terms 2000, 2000, 100 (last) → out_data=49, out_count=3, out_err=0.
- Non-normalised input: single term 4095 (last) → out_data=44, out_count=1, out_err=1. Next operand 5 (last) → out_data=5, out_err=0.
- Backpressure:
  - Stimulus: operand 7, 9 (last), then hold out_ready=0 for 5 cycles while in_valid=1 with data 1000.
  - Required: out_data=16 is stable, in_ready=0 throughout, and the 1000 term is not accepted.
  - After out_ready=1, the next operand starts cleanly (1000 (last) → 1000).
- Reset mid-operand and saturation:
  - Stimulus: terms 3000, 3000, then rst pulse, then 10 (last).
  - Required: out_data=10, out_count=1.
  - Stimulus: 300 terms of 1 with the last flagged.
  - Required: out_data=300, out_count=255 (saturated).
